// File: rtl/ftrace_event_sched_if.sv
// ftrace_event_sched_if: commit slots, event stream and halt/drain signals for ftrace_event_sched.
// evt_depth exists only when FTRACE_DEPTH_EN is defined.
interface ftrace_event_sched_if #(parameter int DW = 8);
  logic s0_valid, s0_is_jal, s0_is_ret, s0_is_rd0;
  logic [31:0] s0_pc, s0_nextpc;
  logic s1_valid, s1_is_jal, s1_is_ret, s1_is_rd0;
  logic [31:0] s1_pc, s1_nextpc;
  logic in_ready, evt_valid, evt_ready, evt_kind;
  logic [31:0] evt_pc, evt_nextpc;
  logic halt, drain_done;
`ifdef FTRACE_DEPTH_EN
  logic [DW-1:0] evt_depth;
`endif
  modport master (
    output s0_valid, s0_is_jal, s0_is_ret, s0_is_rd0, s0_pc, s0_nextpc,
    output s1_valid, s1_is_jal, s1_is_ret, s1_is_rd0, s1_pc, s1_nextpc,
    output evt_ready, halt,
    input in_ready, evt_valid, evt_kind, evt_pc, evt_nextpc, drain_done
`ifdef FTRACE_DEPTH_EN
    , input evt_depth
`endif
  );
  modport slave (
    input s0_valid, s0_is_jal, s0_is_ret, s0_is_rd0, s0_pc, s0_nextpc,
    input s1_valid, s1_is_jal, s1_is_ret, s1_is_rd0, s1_pc, s1_nextpc,
    input evt_ready, halt,
    output in_ready, evt_valid, evt_kind, evt_pc, evt_nextpc, drain_done
`ifdef FTRACE_DEPTH_EN
    , output evt_depth
`endif
  );
endinterface

// File: rtl/ftrace_event_sched.sv
// ftrace_event_sched: orders call/return events from two commit slots into one valid/ready stream with halt drain.
// Optional FTRACE_DEPTH_EN adds a saturating call-depth counter shown on evt_depth.
module ftrace_event_sched #(
  parameter int DEPTH = 8,
  parameter int DW = 8
) (
  input logic clock,
  input logic reset,
  ftrace_event_sched_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  if (DW < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("ftrace_event_sched: DEPTH must be a power of two >= 4 and DW >= 1");
  end
  state_t state, state_next;
  logic [AW:0] count;
  logic [AW-1:0] rp, wp, wp1;
  logic [64:0] mem [DEPTH];
  logic [64:0] ent0, ent1, head;
  logic e0, e1, deq;
  logic [1:0] enq_num;
  always_ff @(posedge clock)
    state <= !reset ? RUN : state_next;
  always_comb
    state_next = state == RUN ? (bus.halt ? DRAIN : RUN)
               : state == DRAIN ? (count == '0 ? DONE : DRAIN)
               : DONE;
  always_comb begin
    bus.in_ready = state == RUN && count <= (AW+1)'(DEPTH - 2);
    bus.drain_done = state == DONE;
    bus.evt_valid = count != '0;
    head = bus.evt_valid ? mem[rp] : '0;
    {bus.evt_kind, bus.evt_pc, bus.evt_nextpc} = head;
  end
  // ret wins over call, so a jal that is also a return yields one return entry
  always_comb begin
    e0 = bus.s0_valid && bus.in_ready && (bus.s0_is_ret || (bus.s0_is_jal && !bus.s0_is_rd0));
    e1 = bus.s1_valid && bus.in_ready && (bus.s1_is_ret || (bus.s1_is_jal && !bus.s1_is_rd0));
    ent0 = {bus.s0_is_ret, bus.s0_pc, bus.s0_nextpc};
    ent1 = {bus.s1_is_ret, bus.s1_pc, bus.s1_nextpc};
    enq_num = {1'b0, e0} + {1'b0, e1};
    wp1 = wp + AW'(e0);
    deq = bus.evt_valid && bus.evt_ready;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      count <= '0;
      rp <= '0;
      wp <= '0;
    end else begin
      count <= count + (AW+1)'(enq_num) - (AW+1)'(deq);
      rp <= rp + AW'(deq);
      wp <= wp + AW'(enq_num);
    end
  always_ff @(posedge clock) begin
    if (e0) mem[wp] <= ent0;
    if (e1) mem[wp1] <= ent1;
  end
`ifdef FTRACE_DEPTH_EN
  logic [DW-1:0] depth_q, depth_dec;
  always_comb begin
    depth_dec = depth_q == '0 ? '0 : depth_q - 1'b1;
    bus.evt_depth = !bus.evt_valid ? '0 : bus.evt_kind ? depth_dec : depth_q;
  end
  always_ff @(posedge clock)
    if (!reset) depth_q <= '0;
    else if (deq) depth_q <= bus.evt_kind ? depth_dec : (&depth_q ? depth_q : depth_q + 1'b1);
`endif
endmodule

// File: tb/tb_ftrace_event_sched.sv
// tb_ftrace_event_sched: directed self-checking bench for ftrace_event_sched (default build; depth test when FTRACE_DEPTH_EN).
module tb_ftrace_event_sched;
  logic clock, reset;
  int checks = 0, failures = 0;
  ftrace_event_sched_if #(.DW(8)) bus ();
  ftrace_event_sched #(.DEPTH(8), .DW(8)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic set_s0(input logic v, j, r, z, input logic [31:0] pc, npc);
    {bus.s0_valid, bus.s0_is_jal, bus.s0_is_ret, bus.s0_is_rd0, bus.s0_pc, bus.s0_nextpc} = {v, j, r, z, pc, npc};
  endtask
  task automatic set_s1(input logic v, j, r, z, input logic [31:0] pc, npc);
    {bus.s1_valid, bus.s1_is_jal, bus.s1_is_ret, bus.s1_is_rd0, bus.s1_pc, bus.s1_nextpc} = {v, j, r, z, pc, npc};
  endtask
  task automatic idle;
    set_s0(0, 0, 0, 0, 0, 0);
    set_s1(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset;
    idle();
    bus.halt = 1'b0;
    bus.evt_ready = 1'b0;
    do_reset();
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL rst_evt_valid got=%b exp=0", bus.evt_valid); end
    checks++; if (bus.drain_done !== 1'b0) begin failures++; $display("FAIL rst_drain_done got=%b exp=0", bus.drain_done); end
    checks++; if ({bus.evt_kind, bus.evt_pc, bus.evt_nextpc} !== 65'd0) begin failures++; $display("FAIL rst_evt_fields got=%b/%h/%h exp=0", bus.evt_kind, bus.evt_pc, bus.evt_nextpc); end
    set_s0(1, 1, 0, 0, 32'h100, 32'h200);
    set_s1(1, 0, 1, 0, 32'h104, 32'h300);
    tick();
    set_s1(0, 0, 0, 0, 0, 0);
    tick();
    idle();
    checks++; if (bus.evt_pc !== 32'h100) begin failures++; $display("FAIL rst_preload_pc got=%h exp=00000100", bus.evt_pc); end
    reset = 1'b0;
    tick();
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL rst_pending_valid got=%b exp=0", bus.evt_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_pending_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.evt_pc !== 32'h0) begin failures++; $display("FAIL rst_pending_pc got=%h exp=0", bus.evt_pc); end
    reset = 1'b1;
    tick();
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL rst_after_valid got=%b exp=0", bus.evt_valid); end
  endtask
  task automatic test_pair;
    bus.evt_ready = 1'b1;
    set_s0(1, 1, 0, 0, 32'h80000010, 32'h80000100);
    set_s1(1, 0, 1, 0, 32'h80000104, 32'h80000014);
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL pair_latency got=%b exp=0", bus.evt_valid); end
    tick();
    idle();
    checks++; if ({bus.evt_valid, bus.evt_kind, bus.evt_pc, bus.evt_nextpc} !== {1'b1, 1'b0, 32'h80000010, 32'h80000100}) begin failures++; $display("FAIL pair_call got=%b/%b/%h/%h exp=1/0/80000010/80000100", bus.evt_valid, bus.evt_kind, bus.evt_pc, bus.evt_nextpc); end
    tick();
    checks++; if ({bus.evt_valid, bus.evt_kind, bus.evt_pc, bus.evt_nextpc} !== {1'b1, 1'b1, 32'h80000104, 32'h80000014}) begin failures++; $display("FAIL pair_ret got=%b/%b/%h/%h exp=1/1/80000104/80000014", bus.evt_valid, bus.evt_kind, bus.evt_pc, bus.evt_nextpc); end
    tick();
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL pair_empty got=%b exp=0", bus.evt_valid); end
  endtask
  task automatic test_full;
    int p = 0;
    bus.evt_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic exp_rdy;
      exp_rdy = k <= 3;
      checks++; if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL full_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, exp_rdy); end
      set_s0(1, 1, 0, 0, 32'h1000 + 32'(8 * p), 32'h9000 + 32'(p));
      set_s1(1, 1, 0, 0, 32'h1004 + 32'(8 * p), 32'h9100 + 32'(p));
      if (bus.in_ready) p++;
      tick();
    end
    idle();
    checks++; if (bus.evt_pc !== 32'h1000) begin failures++; $display("FAIL full_hold_pc got=%h exp=00001000", bus.evt_pc); end
    bus.evt_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      logic exp_rdy;
      exp_rdy = j >= 2;
      checks++; if ({bus.evt_valid, bus.evt_pc} !== {1'b1, 32'h1000 + 32'(4 * j)}) begin failures++; $display("FAIL full_order j=%0d got=%b/%h exp=1/%h", j, bus.evt_valid, bus.evt_pc, 32'h1000 + 32'(4 * j)); end
      checks++; if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL full_ready_back j=%0d got=%b exp=%b", j, bus.in_ready, exp_rdy); end
      tick();
    end
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", bus.evt_valid); end
  endtask
  task automatic test_classify;
    bus.evt_ready = 1'b1;
    set_s0(1, 1, 0, 1, 32'h2000, 32'h2100);
    set_s1(1, 1, 1, 0, 32'h2004, 32'h3000);
    tick();
    set_s0(0, 0, 1, 0, 32'h2008, 32'h2200);
    set_s1(1, 0, 0, 0, 32'h200C, 32'h2300);
    checks++; if ({bus.evt_valid, bus.evt_kind, bus.evt_pc, bus.evt_nextpc} !== {1'b1, 1'b1, 32'h2004, 32'h3000}) begin failures++; $display("FAIL cls_jal_ret got=%b/%b/%h/%h exp=1/1/00002004/00003000", bus.evt_valid, bus.evt_kind, bus.evt_pc, bus.evt_nextpc); end
    tick();
    idle();
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL cls_no_extra got=%b exp=0", bus.evt_valid); end
    tick();
    checks++; if (bus.evt_valid !== 1'b0) begin failures++; $display("FAIL cls_invalid_slots got=%b exp=0", bus.evt_valid); end
  endtask
`ifdef FTRACE_DEPTH_EN
  task automatic test_depth;
    logic [7:0] exp_d [5] = '{8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
    do_reset();
    bus.evt_ready = 1'b0;
    set_s0(1, 1, 0, 0, 32'h4000, 32'h4100);
    set_s1(1, 1, 0, 0, 32'h4004, 32'h4200);
    tick();
    set_s0(1, 0, 1, 0, 32'h4008, 32'h4010);
    set_s1(1, 0, 1, 0, 32'h400C, 32'h4020);
    tick();
    set_s0(1, 0, 1, 0, 32'h4010, 32'h4030);
    set_s1(0, 0, 0, 0, 0, 0);
    tick();
    idle();
    bus.evt_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++; if (bus.evt_depth !== exp_d[j]) begin failures++; $display("FAIL depth j=%0d got=%0d exp=%0d", j, bus.evt_depth, exp_d[j]); end
      tick();
    end
    checks++; if (dut.depth_q !== 8'd0) begin failures++; $display("FAIL depth_final got=%0d exp=0", dut.depth_q); end
  endtask
`endif
  task automatic test_drain;
    do_reset();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    checks++; if ({bus.in_ready, bus.drain_done} !== 2'b00) begin failures++; $display("FAIL drain_empty_step1 got=%b%b exp=00", bus.in_ready, bus.drain_done); end
    tick();
    checks++; if (bus.drain_done !== 1'b1) begin failures++; $display("FAIL drain_empty_done got=%b exp=1", bus.drain_done); end
    do_reset();
    bus.evt_ready = 1'b0;
    set_s0(1, 1, 0, 0, 32'h5000, 32'h5100);
    set_s1(1, 1, 0, 0, 32'h5004, 32'h5200);
    tick();
    set_s0(1, 0, 1, 0, 32'h5008, 32'h5300);
    set_s1(0, 0, 0, 0, 0, 0);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    idle();
    checks++; if ({bus.in_ready, bus.drain_done} !== 2'b00) begin failures++; $display("FAIL drain_in_ready got=%b%b exp=00", bus.in_ready, bus.drain_done); end
    bus.evt_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      checks++; if ({bus.evt_valid, bus.evt_pc} !== {1'b1, 32'h5000 + 32'(4 * j)}) begin failures++; $display("FAIL drain_order j=%0d got=%b/%h exp=1/%h", j, bus.evt_valid, bus.evt_pc, 32'h5000 + 32'(4 * j)); end
      tick();
    end
    checks++; if ({bus.evt_valid, bus.drain_done} !== 2'b00) begin failures++; $display("FAIL drain_count0 got=%b%b exp=00", bus.evt_valid, bus.drain_done); end
    tick();
    checks++; if ({bus.in_ready, bus.drain_done} !== 2'b01) begin failures++; $display("FAIL drain_done got=%b%b exp=01", bus.in_ready, bus.drain_done); end
    bus.halt = 1'b1;
    set_s0(1, 1, 0, 0, 32'h6000, 32'h6100);
    tick();
    bus.halt = 1'b0;
    idle();
    tick();
    checks++; if ({bus.evt_valid, bus.in_ready, bus.drain_done} !== 3'b001) begin failures++; $display("FAIL drain_sticky got=%b%b%b exp=001", bus.evt_valid, bus.in_ready, bus.drain_done); end
    do_reset();
    checks++; if ({bus.in_ready, bus.drain_done} !== 2'b10) begin failures++; $display("FAIL drain_reset got=%b%b exp=10", bus.in_ready, bus.drain_done); end
  endtask
  initial begin
    reset = 1'b0;
    #1;
    test_reset();
    test_pair();
    test_full();
    test_classify();
`ifdef FTRACE_DEPTH_EN
    test_depth();
`endif
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
